branch_target_predictor: RTL

Direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined RV32I core. It predicts next-PC for the fetch stage from PCF. It carries each prediction down to EX alongside the instruction. It consumes the resolved Branch outcome from the EX-stage branch decision logic to detect mispredictions, drive the corrected PC and train the table.

---
 rtl/branch_target_predictor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer with per-entry direction counters.
//   Predicts next-PC for fetch from PCF, carries the prediction through the
//   F->D and D->E pipeline registers, detects mispredictions in EX, drives
//   the corrected PC and trains the table.
//
//   Optional feature: define BTP_TWO_BIT_CTR_EN for 2-bit saturating
//   counters (reset 2'b01, allocate 2'b10). Without it each entry keeps a
//   1-bit last-outcome counter (reset 0, allocate 1).
module branch_target_predictor #(
  parameter int ENTRIES_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE
);

  localparam int ENTRIES = 1 << ENTRIES_LOG2;
  localparam int TAG_W   = 32 - ENTRIES_LOG2 - 2;

`ifdef BTP_TWO_BIT_CTR_EN
  localparam int              CTR_W     = 2;
  localparam logic [CTR_W-1:0] CTR_RST   = 2'b01;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
`else
  localparam int              CTR_W     = 1;
  localparam logic [CTR_W-1:0] CTR_RST   = 1'b0;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

  localparam logic [2:0] NOBRANCH = 3'b000;

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  // Prediction pipe
  logic        pred_taken_d, pred_taken_e;
  logic [31:0] pred_target_d, pred_target_e;

  // Fetch-side lookup
  logic [ENTRIES_LOG2-1:0] idx_f;
  logic [TAG_W-1:0]        tag_f;
  logic                    hit_f;

  assign idx_f       = PCF[ENTRIES_LOG2+1:2];
  assign tag_f       = PCF[31:ENTRIES_LOG2+2];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][CTR_W-1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

  // EX-side resolution
  logic [ENTRIES_LOG2-1:0] idx_e;
  logic [TAG_W-1:0]        tag_e;
  logic                    is_branch_e, hit_e;
  logic                    train_hit, train_alloc, wr_target;
  logic [CTR_W-1:0]        ctr_cur, ctr_next;

  assign idx_e       = PCE[ENTRIES_LOG2+1:2];
  assign tag_e       = PCE[31:ENTRIES_LOG2+2];
  assign is_branch_e = (BranchTypeE != NOBRANCH);
  assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign train_hit   = is_branch_e && hit_e;
  assign train_alloc = is_branch_e && !hit_e && BranchE;
  assign wr_target   = train_alloc || (train_hit && BranchE);
  assign ctr_cur     = ctr_q[idx_e];

  assign MispredictE = is_branch_e &&
                       ((BranchE != pred_taken_e) ||
                        (BranchE && (pred_target_e != BranchTargetE)));
  assign CorrectPCE  = BranchE ? BranchTargetE : PCE + 32'd4;

  // Saturating counter step toward the resolved direction
  always_comb begin
    // NOTE: default assignment first so every path drives ctr_next; no latch.
    ctr_next = ctr_cur;
    if (BranchE) begin
      if (ctr_cur != '1) ctr_next = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_W'(1);
    end
  end

  // Valid bits and counters: cleared on reset, trained on resolved branches
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (train_alloc) begin
      // NOTE: non-blocking assignments so lookups this cycle see old contents.
      valid_q[idx_e] <= 1'b1;
      ctr_q[idx_e]   <= CTR_ALLOC;
    end else if (train_hit) begin
      ctr_q[idx_e]   <= ctr_next;
    end
  end

  // Tag and target payload; gated by valid, so it carries no reset
  always_ff @(posedge clk) begin
    // NOTE: payload RAM is not reset; rst only suppresses a pending write.
    if (!rst && wr_target) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BranchTargetE;
    end
  end

  // Prediction pipe: flush beats stall, stall holds, else advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
      pred_taken_e  <= 1'b0;
      pred_target_e <= '0;
    end else begin
      if (FlushD) begin
        pred_taken_d  <= 1'b0;
        pred_target_d <= '0;
      end else if (!StallD) begin
        pred_taken_d  <= PredTakenF;
        pred_target_d <= PredTargetF;
      end
      if (FlushE) begin
        pred_taken_e  <= 1'b0;
        pred_target_e <= '0;
      end else if (!StallE) begin
        pred_taken_e  <= pred_taken_d;
        pred_target_e <= pred_target_d;
      end
    end
  end

endmodule
